// File: rtl/ssf_io_pkg.sv
// Shared constants for the SSF I/O controller: data width, channel select codes
// and sticky flag bit positions.
package ssf_io_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    CH_IDLE     = 2'b00,
    CH0         = 2'b01,
    CH1         = 2'b10,
    CH_CONFLICT = 2'b11
  } ch_sel_e;

  localparam int FLG_UR0  = 0;
  localparam int FLG_UR1  = 1;
  localparam int FLG_OVF  = 2;
  localparam int FLG_CONF = 3;
  localparam int FLG_W    = 4;
endpackage

// File: rtl/ssf_fifo.sv
// Wrap-around pointer FIFO with an explicit occupancy count. The caller must
// gate push on !full and pop on !empty, except push-while-full paired with a pop.
module ssf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/ssf_io_ctrl.sv
// Two-channel input buffering towards a processor and a tagged output FIFO
// towards a downstream sink, with sticky error flags.
module ssf_io_ctrl
  import ssf_io_pkg::*;
#(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] src_data,
  input  logic                     src_chan,
  input  logic                     src_valid,
  output logic                     src_ready,
  input  logic [1:0]               proc_req_in,
  output logic signed [DATA_W-1:0] proc_in,
  input  logic signed [DATA_W-1:0] proc_io_out,
  input  logic [1:0]               proc_out_en,
  output logic [DATA_W-1:0]        snk_data,
  output logic                     snk_chan,
  output logic                     snk_valid,
  input  logic                     snk_ready,
  input  logic                     clr_flags,
  output logic [FLG_W-1:0]         flags
);
  logic [1:0]              in_push, in_pop, in_full, in_empty, req_sel;
  logic [1:0][DATA_W-1:0]  in_head;
  logic                    out_push_req, out_push, out_pop, out_full, out_empty;
  logic [DATA_W:0]         out_word, out_head;
  logic [DATA_W-1:0]       proc_in_q, proc_in_d;
  logic [FLG_W-1:0]        flags_q, flags_d, flag_set;

  assign req_sel[0] = (proc_req_in == CH0);
  assign req_sel[1] = (proc_req_in == CH1);

  // Handshakes are suppressed during reset so nothing completes in that cycle.
  assign src_ready = !in_full[src_chan] && !rst;

  for (genvar c = 0; c < 2; c++) begin : g_in
    assign in_push[c] = src_valid && src_ready && (src_chan == 1'(c));
    assign in_pop[c]  = req_sel[c] && !in_empty[c] && !rst;

    ssf_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_push[c]),
      .din   (src_data),
      .pop   (in_pop[c]),
      .head  (in_head[c]),
      .full  (in_full[c]),
      .empty (in_empty[c])
    );
  end

  assign out_push_req = (proc_out_en == CH0) || (proc_out_en == CH1);
  assign out_word     = {proc_out_en == CH1, proc_io_out};
  assign snk_valid    = !out_empty && !rst;
  assign out_pop      = snk_valid && snk_ready;
  // A full FIFO still takes a word when the sink drains one in the same cycle.
  assign out_push     = out_push_req && (!out_full || out_pop) && !rst;

  ssf_fifo #(.WIDTH(DATA_W + 1), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_push),
    .din   (out_word),
    .pop   (out_pop),
    .head  (out_head),
    .full  (out_full),
    .empty (out_empty)
  );

  assign snk_data = out_head[DATA_W-1:0];
  assign snk_chan = out_head[DATA_W];

  always_comb begin
    proc_in_d = proc_in_q;
    if (in_pop[0])      proc_in_d = in_head[0];
    else if (in_pop[1]) proc_in_d = in_head[1];
  end

  always_comb begin
    flag_set           = '0;
    flag_set[FLG_UR0]  = req_sel[0] && in_empty[0];
    flag_set[FLG_UR1]  = req_sel[1] && in_empty[1];
    flag_set[FLG_OVF]  = out_push_req && out_full && !out_pop;
    flag_set[FLG_CONF] = (proc_req_in == CH_CONFLICT) || (proc_out_en == CH_CONFLICT);
    // A new event beats a simultaneous clear.
    flags_d = (clr_flags ? '0 : flags_q) | flag_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      proc_in_q <= '0;
      flags_q   <= '0;
    end else begin
      proc_in_q <= proc_in_d;
      flags_q   <= flags_d;
    end
  end

  assign proc_in = proc_in_q;
  assign flags   = flags_q;
endmodule

// File: tb/tb_ssf_io_ctrl.sv
// Directed-vector bench for ssf_io_ctrl; expected values are hand-computed.
module tb_ssf_io_ctrl;
  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] src_data;
  logic               src_chan, src_valid, src_ready;
  logic [1:0]         proc_req_in, proc_out_en;
  logic signed [31:0] proc_in, proc_io_out;
  logic [31:0]        snk_data;
  logic               snk_chan, snk_valid, snk_ready, clr_flags;
  logic [3:0]         flags;

  int n_vec = 0;
  int n_bad = 0;

  ssf_io_ctrl #(.IN_DEPTH(4), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_chan(src_chan),
    .src_valid(src_valid), .src_ready(src_ready), .proc_req_in(proc_req_in),
    .proc_in(proc_in), .proc_io_out(proc_io_out), .proc_out_en(proc_out_en),
    .snk_data(snk_data), .snk_chan(snk_chan), .snk_valid(snk_valid),
    .snk_ready(snk_ready), .clr_flags(clr_flags), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; src_data = '0; src_chan = 1'b0; src_valid = 1'b0;
    proc_req_in = 2'b00; proc_io_out = '0; proc_out_en = 2'b00;
    snk_ready = 1'b0; clr_flags = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_proc_in", proc_in, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_snk_valid", 32'(snk_valid), 32'd1 - 32'd1);
    chk("rst_src_ready", 32'(src_ready), 32'd1);

    // ch0 writes then two pops
    src_valid = 1'b1; src_chan = 1'b0; src_data = -5; step();
    src_data = 7; step();
    src_valid = 1'b0; proc_req_in = 2'b01; step();
    chk("pop1", proc_in, -32'sd5);
    step();
    chk("pop2", proc_in, 32'd7);
    proc_req_in = 2'b00; step();
    chk("hold", proc_in, 32'd7);
    chk("flags_clean", 32'(flags), 32'd0);

    // underrun on ch1, then clear
    proc_req_in = 2'b10; step();
    proc_req_in = 2'b00;
    chk("ur1_proc_in", proc_in, 32'd7);
    chk("ur1_flags", 32'(flags), 32'b0010);
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    chk("clr_flags", 32'(flags), 32'd0);

    // fill ch0
    src_valid = 1'b1; src_chan = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_data = 10 + i; step();
    end
    src_valid = 1'b0; #1;
    chk("full_rdy_ch0", 32'(src_ready), 32'd0);
    src_chan = 1'b1; #1;
    chk("full_rdy_ch1", 32'(src_ready), 32'd1);
    src_chan = 1'b0; src_valid = 1'b1; src_data = 99; step();
    src_valid = 1'b0; proc_req_in = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_ch0", proc_in, 32'(10 + i));
    end
    step();
    chk("fifth_refused", proc_in, 32'd13);
    chk("ur0_flags", 32'(flags), 32'b0001);

    // write and pop on empty FIFO: no bypass, sample retained
    src_valid = 1'b1; src_data = 42; step();
    src_valid = 1'b0;
    chk("nobypass", proc_in, 32'd13);
    chk("nobypass_flags", 32'(flags), 32'b0001);
    clr_flags = 1'b1; step();
    chk("kept_sample", proc_in, 32'd42);
    chk("clr_after_pop", 32'(flags), 32'd0);
    step();
    chk("set_wins_clr", 32'(flags), 32'b0001);
    proc_req_in = 2'b00; step(); clr_flags = 1'b0;
    chk("clr2", 32'(flags), 32'd0);

    // output overflow
    snk_ready = 1'b0; proc_out_en = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      proc_io_out = i; step();
    end
    proc_out_en = 2'b00;
    chk("ovf_flags", 32'(flags), 32'b0100);
    chk("ovf_valid", 32'(snk_valid), 32'd1);
    step();
    chk("stall_data", snk_data, 32'd1);
    snk_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("snk_data", snk_data, 32'(i));
      chk("snk_chan0", 32'(snk_chan), 32'd0);
      step();
    end
    chk("snk_empty", 32'(snk_valid), 32'd0);
    snk_ready = 1'b0; clr_flags = 1'b1; step(); clr_flags = 1'b0;

    // push while full with a simultaneous pop
    proc_out_en = 2'b10;
    for (int i = 20; i < 24; i++) begin
      proc_io_out = i; step();
    end
    proc_io_out = 24; snk_ready = 1'b1; step();
    proc_out_en = 2'b00;
    chk("full_pop_push_flags", 32'(flags), 32'd0);
    for (int i = 21; i <= 24; i++) begin
      #1;
      chk("snk_data_ch1", snk_data, 32'(i));
      chk("snk_chan1", 32'(snk_chan), 32'd1);
      step();
    end
    chk("snk_empty2", 32'(snk_valid), 32'd0);
    snk_ready = 1'b0;

    // conflicts
    src_valid = 1'b1; src_chan = 1'b0; src_data = 55; step();
    src_valid = 1'b0; proc_req_in = 2'b11; proc_out_en = 2'b11; step();
    proc_req_in = 2'b00; proc_out_en = 2'b00;
    chk("conf_proc_in", proc_in, 32'd42);
    chk("conf_flags", 32'(flags), 32'b1000);
    chk("conf_nopush", 32'(snk_valid), 32'd0);
    proc_req_in = 2'b01; step(); proc_req_in = 2'b00;
    chk("conf_nopop", proc_in, 32'd55);
    clr_flags = 1'b1; step(); clr_flags = 1'b0;

    // reset with buffered data
    proc_out_en = 2'b01;
    for (int i = 7; i <= 9; i++) begin
      proc_io_out = i; step();
    end
    proc_out_en = 2'b00;
    src_valid = 1'b1; src_chan = 1'b1; src_data = 77; step();
    src_valid = 1'b0; proc_req_in = 2'b11; step(); proc_req_in = 2'b00;
    chk("pre_rst_valid", 32'(snk_valid), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("post_rst_valid", 32'(snk_valid), 32'd0);
    chk("post_rst_proc_in", proc_in, 32'd0);
    chk("post_rst_flags", 32'(flags), 32'd0);
    #1;
    chk("post_rst_ready", 32'(src_ready), 32'd1);
    proc_req_in = 2'b10; step(); proc_req_in = 2'b00;
    chk("rst_discard_ch1", 32'(flags), 32'b0010);
    chk("rst_discard_pin", proc_in, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
